cross_bar_rob_param: RTL and testbench

//  Per-channel return-path reorder buffer between NUM_BANKS cache banks and one mcash read channel.
//  On request kickoff it allocates a ROB slot in the target bank, returns that slot number to the requester,
//  and logs the bank id in a keep-order FIFO (KOF).
//  It takes out-of-order bank responses into per-bank ROBs and returns data in kickoff order over a

---
 rtl/cross_bar_rob_param.sv | 194 +++++++++++++++++++
 tb/tb_cross_bar_rob_param.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cross_bar_rob_param.sv
// -----------------------------------------------------------------------------
// cross_bar_rob_param
//   Return-path reorder buffer for one read channel sitting behind NUM_BANKS
//   cache banks. A kickoff allocates the next slot of the target bank's ROB and
//   logs the bank id in a keep-order FIFO (KOF). Banks answer out of order into
//   their own ROB; data leaves over a registered valid/ready port strictly in
//   kickoff order. Per-bank credits stop a bank's ROB from being oversubscribed.
//
// Ports
//   clk_i, rst_i               clock, synchronous active-low reset
//   rd_req_valid_i/ready_o     kickoff handshake
//   rd_req_bank_id_i           kickoff target bank
//   rd_req_rob_num_o           slot allocated in the target bank
//   sc_xbar_valid_i            per-bank response valid
//   sc_xbar_allowIn_o          per-bank response accept
//   sc_xbar_ch_id_i            per-bank response channel id (flattened)
//   sc_xbar_rob_num_i          per-bank response ROB slot (flattened)
//   sc_xbar_data_i             per-bank response data (flattened)
//   ch_rtn_data_valid_o/ready_i in-order return handshake
//   ch_rtn_data_o              return data
//   rob_err_o                  sticky flag: a response hit an occupied slot
// -----------------------------------------------------------------------------
module cross_bar_rob_param #(
    parameter int CHANNEL_ID = 0,
    parameter int NUM_BANKS  = 4,
    parameter int BANK_W     = 2,
    parameter int CH_W       = 2,
    parameter int DW         = 128,
    parameter int ROB_AW     = 3,
    parameter int KOF_AW     = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        rd_req_valid_i,
    output logic                        rd_req_ready_o,
    input  logic [BANK_W-1:0]           rd_req_bank_id_i,
    output logic [ROB_AW-1:0]           rd_req_rob_num_o,
    input  logic [NUM_BANKS-1:0]        sc_xbar_valid_i,
    output logic [NUM_BANKS-1:0]        sc_xbar_allowIn_o,
    input  logic [NUM_BANKS*CH_W-1:0]   sc_xbar_ch_id_i,
    input  logic [NUM_BANKS*ROB_AW-1:0] sc_xbar_rob_num_i,
    input  logic [NUM_BANKS*DW-1:0]     sc_xbar_data_i,
    output logic                        ch_rtn_data_valid_o,
    input  logic                        ch_rtn_data_ready_i,
    output logic [DW-1:0]               ch_rtn_data_o,
    output logic                        rob_err_o
);

    localparam int ROB_DEPTH = 2 ** ROB_AW;
    localparam int KOF_DEPTH = 2 ** KOF_AW;

    localparam logic [ROB_AW:0]    CRED_MAX_C = (ROB_AW + 1)'(ROB_DEPTH);
    localparam logic [ROB_AW:0]    CRED_ONE_C = (ROB_AW + 1)'(1'b1);
    localparam logic [ROB_AW-1:0]  PTR_ONE_C  = ROB_AW'(1'b1);
    localparam logic [KOF_AW:0]    KOF_ONE_C  = (KOF_AW + 1)'(1'b1);
    localparam logic [CH_W-1:0]    CH_ID_C    = CH_W'(CHANNEL_ID);
    localparam logic [ROB_DEPTH-1:0] SLOT_ONE_C = ROB_DEPTH'(1'b1);

    // State
    logic [BANK_W-1:0]    kof_mem_r   [KOF_DEPTH];
    logic [KOF_AW:0]      kof_wr_ptr_r;
    logic [KOF_AW:0]      kof_rd_ptr_r;
    logic [ROB_DEPTH-1:0] slot_vld_r  [NUM_BANKS];
    logic [DW-1:0]        rob_data_r  [NUM_BANKS][ROB_DEPTH];
    logic [ROB_AW-1:0]    alloc_ptr_r [NUM_BANKS];
    logic [ROB_AW-1:0]    head_ptr_r  [NUM_BANKS];
    logic [ROB_AW:0]      credit_r    [NUM_BANKS];
    logic                 rtn_valid_r;
    logic [DW-1:0]        rtn_data_r;
    logic                 rob_err_r;

    // Per-bank views of the flattened response buses and next-state terms
    logic [CH_W-1:0]      bk_ch_s     [NUM_BANKS];
    logic [ROB_AW-1:0]    bk_rob_s    [NUM_BANKS];
    logic [DW-1:0]        bk_data_s   [NUM_BANKS];
    logic [ROB_DEPTH-1:0] set_mask_s  [NUM_BANKS];
    logic [ROB_DEPTH-1:0] clr_mask_s  [NUM_BANKS];
    logic [ROB_DEPTH-1:0] slot_vld_nxt_s [NUM_BANKS];
    logic [ROB_AW:0]      credit_nxt_s   [NUM_BANKS];
    logic [NUM_BANKS-1:0] wr_hit_s;
    logic [NUM_BANKS-1:0] wr_ok_s;
    logic [NUM_BANKS-1:0] wr_err_s;
    logic [NUM_BANKS-1:0] inc_s;
    logic [NUM_BANKS-1:0] dec_s;

    logic                 kof_empty_s;
    logic                 kof_full_s;
    logic [BANK_W-1:0]    hd_s;
    logic                 push_s;
    logic                 pop_s;

    // Extra MSB on the KOF pointers separates full from empty.
    assign kof_empty_s = (kof_wr_ptr_r == kof_rd_ptr_r);
    assign kof_full_s  = (kof_wr_ptr_r[KOF_AW] != kof_rd_ptr_r[KOF_AW]) &&
                         (kof_wr_ptr_r[KOF_AW-1:0] == kof_rd_ptr_r[KOF_AW-1:0]);
    assign hd_s        = kof_mem_r[kof_rd_ptr_r[KOF_AW-1:0]];

    assign rd_req_ready_o   = ~kof_full_s & (credit_r[rd_req_bank_id_i] < CRED_MAX_C);
    assign rd_req_rob_num_o = alloc_ptr_r[rd_req_bank_id_i];
    assign push_s           = rd_req_valid_i & rd_req_ready_o;

    // A pop needs the head bank's head slot filled and room in the output register.
    assign pop_s = ~kof_empty_s & slot_vld_r[hd_s][head_ptr_r[hd_s]] &
                   (~rtn_valid_r | ch_rtn_data_ready_i);

    for (genvar gb = 0; gb < NUM_BANKS; gb++) begin : g_bank
        assign bk_ch_s[gb]   = sc_xbar_ch_id_i[gb*CH_W +: CH_W];
        assign bk_rob_s[gb]  = sc_xbar_rob_num_i[gb*ROB_AW +: ROB_AW];
        assign bk_data_s[gb] = sc_xbar_data_i[gb*DW +: DW];
        assign wr_hit_s[gb]  = sc_xbar_valid_i[gb] & (bk_ch_s[gb] == CH_ID_C);
        // A hit on an occupied slot is refused and flagged; it never overwrites.
        assign wr_err_s[gb]  = wr_hit_s[gb] & slot_vld_r[gb][bk_rob_s[gb]];
        assign wr_ok_s[gb]   = wr_hit_s[gb] & ~slot_vld_r[gb][bk_rob_s[gb]];
        assign sc_xbar_allowIn_o[gb] = ~wr_err_s[gb];
        assign inc_s[gb]     = push_s & (rd_req_bank_id_i == BANK_W'(gb));
        assign dec_s[gb]     = pop_s & (hd_s == BANK_W'(gb));
        assign set_mask_s[gb] = wr_ok_s[gb] ? (SLOT_ONE_C << bk_rob_s[gb]) : {ROB_DEPTH{1'b0}};
        assign clr_mask_s[gb] = dec_s[gb] ? (SLOT_ONE_C << head_ptr_r[gb]) : {ROB_DEPTH{1'b0}};
    end

    // Next credit and slot-valid values per bank; kickoff+pop on one bank cancels.
    always_comb begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            case ({inc_s[b], dec_s[b]})
                2'b10:   credit_nxt_s[b] = credit_r[b] + CRED_ONE_C;
                2'b01:   credit_nxt_s[b] = credit_r[b] - CRED_ONE_C;
                default: credit_nxt_s[b] = credit_r[b];
            endcase
            slot_vld_nxt_s[b] = (slot_vld_r[b] | set_mask_s[b]) & ~clr_mask_s[b];
        end
    end

    // Control state: KOF, pointers, credits, slot valid bits, output register, error flag.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            kof_wr_ptr_r <= {(KOF_AW + 1){1'b0}};
            kof_rd_ptr_r <= {(KOF_AW + 1){1'b0}};
            for (int k = 0; k < KOF_DEPTH; k++) begin
                kof_mem_r[k] <= {BANK_W{1'b0}};
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                slot_vld_r[b]  <= {ROB_DEPTH{1'b0}};
                alloc_ptr_r[b] <= {ROB_AW{1'b0}};
                head_ptr_r[b]  <= {ROB_AW{1'b0}};
                credit_r[b]    <= {(ROB_AW + 1){1'b0}};
            end
            rtn_valid_r <= 1'b0;
            rtn_data_r  <= {DW{1'b0}};
            rob_err_r   <= 1'b0;
        end else begin
            if (push_s) begin
                kof_mem_r[kof_wr_ptr_r[KOF_AW-1:0]] <= rd_req_bank_id_i;
                kof_wr_ptr_r <= kof_wr_ptr_r + KOF_ONE_C;
            end
            if (pop_s) begin
                kof_rd_ptr_r <= kof_rd_ptr_r + KOF_ONE_C;
            end
            for (int b = 0; b < NUM_BANKS; b++) begin
                slot_vld_r[b] <= slot_vld_nxt_s[b];
                credit_r[b]   <= credit_nxt_s[b];
                if (inc_s[b]) begin
                    alloc_ptr_r[b] <= alloc_ptr_r[b] + PTR_ONE_C;
                end
                if (dec_s[b]) begin
                    head_ptr_r[b] <= head_ptr_r[b] + PTR_ONE_C;
                end
            end
            // Data holds whenever nothing pops; valid only drops once accepted.
            if (pop_s) begin
                rtn_valid_r <= 1'b1;
                rtn_data_r  <= rob_data_r[hd_s][head_ptr_r[hd_s]];
            end else if (ch_rtn_data_ready_i) begin
                rtn_valid_r <= 1'b0;
            end
            if (|wr_err_s) begin
                rob_err_r <= 1'b1;
            end
        end
    end

    // ROB data storage; contents are qualified by the slot valid bits, so no reset.
    always_ff @(posedge clk_i) begin
        for (int b = 0; b < NUM_BANKS; b++) begin
            if (wr_ok_s[b]) begin
                rob_data_r[b][bk_rob_s[b]] <= bk_data_s[b];
            end
        end
    end

    assign ch_rtn_data_valid_o = rtn_valid_r;
    assign ch_rtn_data_o       = rtn_data_r;
    assign rob_err_o           = rob_err_r;

endmodule

// File: tb/tb_cross_bar_rob_param.sv
// -----------------------------------------------------------------------------
// tb_cross_bar_rob_param
//   Directed bench for cross_bar_rob_param (default parameters). A queue-based
//   model of the kickoff order and of which (bank, slot) answers have arrived
//   predicts every output each cycle; directed literal checks pin the model.
// -----------------------------------------------------------------------------
module tb_cross_bar_rob_param;

    logic          clk = 1'b0;
    logic          rst_i;
    logic          req_v;
    logic          req_ready;
    logic [1:0]    req_bank;
    logic [2:0]    rob_num;
    logic [3:0]    xv;
    logic [3:0]    allow;
    logic [7:0]    xch;
    logic [11:0]   xrob;
    logic [511:0]  xdata;
    logic          rtn_v;
    logic          rtn_rdy;
    logic [127:0]  rtn_d;
    logic          err;

    int n_vec = 0;
    int n_err = 0;

    cross_bar_rob_param #(
        .CHANNEL_ID(0), .NUM_BANKS(4), .BANK_W(2), .CH_W(2),
        .DW(128), .ROB_AW(3), .KOF_AW(4)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst_i),
        .rd_req_valid_i      (req_v),
        .rd_req_ready_o      (req_ready),
        .rd_req_bank_id_i    (req_bank),
        .rd_req_rob_num_o    (rob_num),
        .sc_xbar_valid_i     (xv),
        .sc_xbar_allowIn_o   (allow),
        .sc_xbar_ch_id_i     (xch),
        .sc_xbar_rob_num_i   (xrob),
        .sc_xbar_data_i      (xdata),
        .ch_rtn_data_valid_o (rtn_v),
        .ch_rtn_data_ready_i (rtn_rdy),
        .ch_rtn_data_o       (rtn_d),
        .rob_err_o           (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct { int bank; int slot; } ent_t;
    ent_t          kq[$];
    bit            arrived [4][8];
    logic [127:0]  sdata   [4][8];
    int            alloc_cnt [4];
    bit            m_valid;
    logic [127:0]  m_data;
    bit            m_err;
    bit            model_init = 1'b0;
    bit            m_acc, m_pop;
    int            m_rb;
    ent_t          m_e;

    function automatic int cnt_bank(input int b);
        int c = 0;
        foreach (kq[i]) if (kq[i].bank == b) c++;
        return c;
    endfunction

    initial forever begin
        @(posedge clk);
        if (!rst_i) begin
            kq.delete();
            for (int b = 0; b < 4; b++) begin
                alloc_cnt[b] = 0;
                for (int s = 0; s < 8; s++) arrived[b][s] = 1'b0;
            end
            m_valid = 1'b0; m_data = 128'h0; m_err = 1'b0; model_init = 1'b1;
        end else begin
            m_acc = req_v && (kq.size() < 16) && (cnt_bank(int'(req_bank)) < 8);
            m_pop = 1'b0;
            if (kq.size() > 0)
                if (arrived[kq[0].bank][kq[0].slot] && (!m_valid || rtn_rdy)) m_pop = 1'b1;
            for (int b = 0; b < 4; b++) begin
                if (xv[b] && xch[b*2 +: 2] == 2'd0) begin
                    m_rb = int'(xrob[b*3 +: 3]);
                    if (arrived[b][m_rb]) m_err = 1'b1;
                    else begin
                        arrived[b][m_rb] = 1'b1;
                        sdata[b][m_rb]   = xdata[b*128 +: 128];
                    end
                end
            end
            if (m_pop) begin
                m_e = kq.pop_front();
                arrived[m_e.bank][m_e.slot] = 1'b0;
                m_valid = 1'b1;
                m_data  = sdata[m_e.bank][m_e.slot];
            end else if (rtn_rdy) begin
                m_valid = 1'b0;
            end
            if (m_acc) begin
                kq.push_back('{bank: int'(req_bank), slot: alloc_cnt[req_bank] % 8});
                alloc_cnt[req_bank]++;
            end
        end
    end

    // Per-cycle comparison at mid-cycle (inputs change only just after posedge).
    initial forever begin
        logic [3:0] ea;
        @(negedge clk);
        if (model_init) begin
            check("req_ready", req_ready,
                  (kq.size() < 16 && cnt_bank(int'(req_bank)) < 8));
            check("rob_num", rob_num, 128'(alloc_cnt[req_bank] % 8));
            for (int b = 0; b < 4; b++)
                ea[b] = !(xv[b] && xch[b*2 +: 2] == 2'd0 && arrived[b][int'(xrob[b*3 +: 3])]);
            check("allowIn", allow, ea);
            check("rtn_valid", rtn_v, m_valid);
            check("rtn_data", rtn_d, m_data);
            check("rob_err", err, m_err);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        req_v = 1'b0; xv = 4'b0000;
    endtask

    task automatic kick(input int b);
        req_v = 1'b1; req_bank = b[1:0];
    endtask

    task automatic bw(input int b, input int slot, input logic [127:0] d, input int ch);
        xv[b] = 1'b1;
        xch[b*2 +: 2]     = ch[1:0];
        xrob[b*3 +: 3]    = slot[2:0];
        xdata[b*128 +: 128] = d;
    endtask

    function automatic logic [127:0] dv(input int tag);
        return {96'hD00D_0000_0000_0000_0000_0000, 32'(tag)};
    endfunction

    initial begin
        rst_i = 1'b0; req_v = 1'b0; req_bank = 2'd0; xv = 4'b0; xch = 8'h0;
        xrob = 12'h0; xdata = 512'h0; rtn_rdy = 1'b1;
        repeat (3) cyc();
        #2;
        check("reset_valid", rtn_v, 1'b0);
        check("reset_data", rtn_d, 128'h0);
        check("reset_err", err, 1'b0);
        rst_i = 1'b1;

        // 1: single kickoff and return, latency two edges after the write
        kick(0); #2;
        check("t1_rob_num", rob_num, 3'd0);
        check("t1_ready", req_ready, 1'b1);
        cyc(); idle(); bw(0, 0, dv(16'hA), 0);
        cyc(); idle(); #2;
        check("t1_valid_early", rtn_v, 1'b0);
        cyc(); #2;
        check("t1_valid", rtn_v, 1'b1);
        check("t1_data", rtn_d, dv(16'hA));
        cyc(); #2;
        check("t1_drop", rtn_v, 1'b0);

        // 2: reverse-order responses come out in kickoff order
        kick(1); cyc(); kick(2); cyc(); kick(3); cyc(); idle();
        bw(3, 0, dv(3), 0); cyc(); idle();
        bw(2, 0, dv(2), 0); cyc(); idle();
        bw(1, 0, dv(1), 0); cyc(); idle();
        cyc(); #2; check("t2_beat1", rtn_d, dv(1));
        cyc(); #2; check("t2_beat2", rtn_d, dv(2));
        cyc(); #2; check("t2_beat3", rtn_d, dv(3));
        cyc(); #2; check("t2_idle", rtn_v, 1'b0);

        // 3: credit exhaustion on bank2 and slot wrap
        rst_i = 1'b0; cyc(); cyc(); rst_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            kick(2); #2;
            check("t3_rob_num", rob_num, 128'(i));
            cyc();
        end
        idle(); req_bank = 2'd2; #2;
        check("t3_full_ready", req_ready, 1'b0);
        check("t3_wrap_rob", rob_num, 3'd0);
        bw(2, 0, dv(32'h20), 0); cyc(); idle();
        cyc(); #2;
        check("t3_ready_back", req_ready, 1'b1);
        check("t3_rob_after", rob_num, 3'd0);
        check("t3_data", rtn_d, dv(32'h20));

        // 4: back-pressure holds output, release gives back-to-back beats
        cyc();
        rtn_rdy = 1'b0;
        bw(2, 1, dv(32'h21), 0); cyc(); idle();
        bw(2, 2, dv(32'h22), 0); cyc(); idle();
        bw(2, 3, dv(32'h23), 0); cyc(); idle();
        for (int i = 0; i < 5; i++) begin
            cyc(); #2;
            check("t4_hold_valid", rtn_v, 1'b1);
            check("t4_hold_data", rtn_d, dv(32'h21));
        end
        rtn_rdy = 1'b1;
        cyc(); #2; check("t4_beat2", rtn_d, dv(32'h22));
        cyc(); #2; check("t4_beat3", rtn_d, dv(32'h23));
        cyc(); #2; check("t4_done", rtn_v, 1'b0);

        // 5: double write on bank1 slot0
        kick(1); cyc(); idle();
        bw(1, 0, dv(32'h51), 0); #2;
        check("t5_allow_first", allow, 4'b1111);
        cyc(); idle();
        bw(1, 0, dv(32'h52), 0); #2;
        check("t5_allow_second", allow, 4'b1101);
        check("t5_err_before", err, 1'b0);
        cyc(); idle(); #2;
        check("t5_err", err, 1'b1);
        for (int s = 4; s < 8; s++) begin
            bw(2, s, dv(32'h20 + s), 0); cyc(); idle();
        end
        cyc(); #2; check("t5_bank2_last", rtn_d, dv(32'h27));
        cyc(); #2; check("t5_unchanged", rtn_d, dv(32'h51));
        cyc(); #2; check("t5_idle", rtn_v, 1'b0);

        // 6: foreign channel ignored, all banks write at once, reset mid-stream
        bw(0, 0, dv(32'h60), 1); #2;
        check("t6_allow_foreign", allow, 4'b1111);
        cyc(); idle(); kick(0); cyc(); idle();
        cyc(); cyc(); #2;
        check("t6_no_slot", rtn_v, 1'b0);
        kick(1); cyc(); kick(2); cyc(); kick(3); cyc(); idle();
        bw(0, 0, dv(32'h70), 0); bw(1, 1, dv(32'h71), 0);
        bw(2, 0, dv(32'h72), 0); bw(3, 0, dv(32'h73), 0);
        cyc(); idle();
        cyc(); #2; check("t6_all_b0", rtn_d, dv(32'h70));
        cyc(); #2; check("t6_all_b1", rtn_d, dv(32'h71));
        kick(0); #2;
        check("t6_rob_pre", rob_num, 3'd1);
        rst_i = 1'b0; idle();
        cyc(); #2;
        check("t6_rst_valid", rtn_v, 1'b0);
        check("t6_rst_data", rtn_d, 128'h0);
        check("t6_rst_err", err, 1'b0);
        check("t6_rst_rob", rob_num, 3'd0);
        rst_i = 1'b1;
        cyc(); cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
